// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// It sits between the CPU MEM stage and a 256-bit block data memory, and
// serves 32-bit word loads and stores from the pipeline.
// On a miss it raises p1_stall_o, writes back a dirty victim if there is
// one, refills the line over an enable/ack handshake, and then lets the
// held request complete as a hit.
//
// Ports
//   clk_i, rst_i      : clock, synchronous active-high reset
//   p1_addr_i         : CPU byte address (word [4:2], index, tag)
//   p1_data_i         : store data
//   p1_MemRead_i      : load request
//   p1_MemWrite_i     : store request (wins when both are high)
//   p1_data_o         : load data (combinational on a hit, else 0)
//   p1_stall_o        : pipeline freeze (combinational)
//   mem_addr_o        : block address, bits [4:0] always 0
//   mem_data_o        : writeback line (0 outside WRITEBACK)
//   mem_enable_o      : memory request
//   mem_write_o       : 1 = write, 0 = read
//   mem_data_i        : refill line
//   mem_ack_i         : one-cycle completion pulse
module l1_dcache_ctrl #(
  parameter int unsigned LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = 32 - 5 - INDEX_W;
  localparam int unsigned LINE_W  = 256;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state, state_nxt;

  // Line storage; only valid/dirty are cleared on reset.
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Request decode
  logic [2:0]         word;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req;
  logic               is_store;
  logic               hit;
  logic               victim_dirty;
  logic [LINE_W-1:0]  line;
  logic [31:0]        sel_word;
  logic               addr_lo_unused;

  assign word           = p1_addr_i[4:2];
  assign idx            = p1_addr_i[4+INDEX_W:5];
  assign req_tag        = p1_addr_i[31:5+INDEX_W];
  assign addr_lo_unused = ^p1_addr_i[1:0];
  assign req            = p1_MemRead_i | p1_MemWrite_i;
  assign is_store       = p1_MemWrite_i;
  assign hit            = valid_q[idx] & (tag_q[idx] == req_tag);
  assign victim_dirty   = valid_q[idx] & dirty_q[idx];
  assign line           = data_q[idx];
  assign sel_word       = line[{word, 5'b0} +: 32];

  logic store_hit;
  logic refill_done;

  // Next state, pipeline/memory outputs and array write strobes
  always_comb begin
    state_nxt    = state;
    p1_stall_o   = 1'b0;
    p1_data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    store_hit    = 1'b0;
    refill_done  = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (is_store) begin
              store_hit = 1'b1;
            end else begin
              p1_data_o = sel_word;
            end
          end else begin
            p1_stall_o = 1'b1;
            state_nxt  = victim_dirty ? WRITEBACK : REFILL;
          end
        end
      end

      WRITEBACK: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = line;
        if (mem_ack_i) begin
          state_nxt = REFILL;
        end
      end

      REFILL: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b0};
        if (mem_ack_i) begin
          refill_done = 1'b1;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and line status bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state <= state_nxt;
      if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
      if (refill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: never cleared, just not written while in reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (store_hit) begin
        data_q[idx][{word, 5'b0} +: 32] <= p1_data_i;
      end
      if (refill_done) begin
        data_q[idx] <= mem_data_i;
        tag_q[idx]  <= req_tag;
      end
    end
  end

endmodule
